// File: rtl/load_sequencer_if.sv
// Shadow-table configuration bus for load_sequencer: segment writes and the commit request.
interface load_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [5:0]       cfg_load;
    logic [CNT_W-1:0] cfg_dwell;
    logic             cfg_commit;

    modport master (output cfg_we, cfg_addr, cfg_load, cfg_dwell, cfg_commit);
    modport slave  (input  cfg_we, cfg_addr, cfg_load, cfg_dwell, cfg_commit);
endinterface

// File: rtl/load_sequencer.sv
// Periodic load sequencer: steps a 4-segment {load, dwell} table and requests commutation.
// Optional macro SEQ_SKIP_SAME_EN suppresses start when a segment's load is already driven.
module load_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    load_sequencer_if.slave  cfg,
    input  logic             short_in,
    input  logic             fault_clr,
    output logic [5:0]       desired_load,
    output logic             start,
    output logic [1:0]       seg_idx,
    output logic             period_tick,
    output logic             fault
);
    // state    | meaning
    // ST_IDLE  | outputs NUL, waiting for en and a non-empty active table
    // ST_RUN   | stepping segments, wrapping periodically
    // ST_DRAIN | en dropped, finishing the current period then NUL
    // ST_FAULT | short seen, outputs NUL until fault_clr with short_in low
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [5:0]       sh_load_q   [4];
    logic [5:0]       sh_load_d   [4];
    logic [CNT_W-1:0] sh_dwell_q  [4];
    logic [CNT_W-1:0] sh_dwell_d  [4];
    logic [5:0]       act_load_q  [4];
    logic [5:0]       act_load_d  [4];
    logic [CNT_W-1:0] act_dwell_q [4];
    logic [CNT_W-1:0] act_dwell_d [4];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       seg_q, seg_d;
    logic [5:0]       load_q, load_d;
    logic             start_q, start_d;
    logic             tick_q, tick_d;
    logic             fault_q, fault_d;
    logic             pend_q, pend_d;

    logic [3:0]       act_nz, sh_nz;
    logic [2:0]       act_first, act_next, sh_first;
    logic             enter, ent_sh;
    logic [1:0]       ent_idx;
    logic [5:0]       ent_load;
    logic [CNT_W-1:0] ent_dwell;

    // {found, index} of the first non-empty segment at or after 'from', with wrap
    function automatic logic [2:0] find_nz(input logic [3:0] nz, input logic [1:0] from);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = from + 2'(k);
            if (!res[2] && nz[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            act_nz[i] = |act_dwell_q[i];
            sh_nz[i]  = |sh_dwell_q[i];
        end
    end

    assign act_first = find_nz(act_nz, 2'd0);
    assign act_next  = find_nz(act_nz, seg_q + 2'd1);
    assign sh_first  = find_nz(sh_nz, 2'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seg_d       = seg_q;
        load_d      = load_q;
        start_d     = 1'b0;
        tick_d      = 1'b0;
        fault_d     = fault_q;
        pend_d      = pend_q;
        sh_load_d   = sh_load_q;
        sh_dwell_d  = sh_dwell_q;
        act_load_d  = act_load_q;
        act_dwell_d = act_dwell_q;
        enter       = 1'b0;
        ent_sh      = 1'b0;
        ent_idx     = 2'd0;
        ent_load    = '0;
        ent_dwell   = '0;

        if (cfg.cfg_we) begin
            sh_load_d[cfg.cfg_addr]  = cfg.cfg_load;
            sh_dwell_d[cfg.cfg_addr] = cfg.cfg_dwell;
        end

        if (short_in) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            load_d  = '0;
            seg_d   = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg.cfg_commit) begin
                        act_load_d  = sh_load_q;
                        act_dwell_d = sh_dwell_q;
                    end
                    pend_d = 1'b0;
                    if (en && act_first[2]) begin
                        state_d = ST_RUN;
                        enter   = 1'b1;
                        ent_idx = act_first[1:0];
                    end
                end
                ST_FAULT: begin
                    if (cfg.cfg_commit) begin
                        act_load_d  = sh_load_q;
                        act_dwell_d = sh_dwell_q;
                    end
                    if (fault_clr) begin
                        state_d = ST_IDLE;
                        fault_d = 1'b0;
                    end
                end
                default: begin
                    state_d = en ? ST_RUN : ST_DRAIN;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cfg.cfg_commit) pend_d = 1'b1;
                    end else if (act_next[2] && (act_next[1:0] > seg_q)) begin
                        enter   = 1'b1;
                        ent_idx = act_next[1:0];
                        if (cfg.cfg_commit) pend_d = 1'b1;
                    end else begin
                        // period wrap: a pending or same-cycle commit swaps tables here
                        if (pend_q || cfg.cfg_commit) begin
                            act_load_d  = sh_load_q;
                            act_dwell_d = sh_dwell_q;
                            ent_sh      = 1'b1;
                        end
                        pend_d = 1'b0;
                        if (en && (ent_sh ? sh_first[2] : act_first[2])) begin
                            enter   = 1'b1;
                            tick_d  = 1'b1;
                            ent_idx = ent_sh ? sh_first[1:0] : act_first[1:0];
                        end else begin
                            state_d = ST_IDLE;
                            load_d  = '0;
                            seg_d   = '0;
                            start_d = 1'b1;
                        end
                    end
                end
            endcase
        end

        if (enter) begin
            ent_load  = ent_sh ? sh_load_q[ent_idx]  : act_load_q[ent_idx];
            ent_dwell = ent_sh ? sh_dwell_q[ent_idx] : act_dwell_q[ent_idx];
            seg_d     = ent_idx;
            load_d    = ent_load;
            cnt_d     = ent_dwell - CNT_W'(1);
`ifdef SEQ_SKIP_SAME_EN
            start_d   = (ent_load != load_q);
`else
            start_d   = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seg_q   <= '0;
            load_q  <= '0;
            start_q <= 1'b0;
            tick_q  <= 1'b0;
            fault_q <= 1'b0;
            pend_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sh_load_q[i]   <= '0;
                sh_dwell_q[i]  <= '0;
                act_load_q[i]  <= '0;
                act_dwell_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seg_q       <= seg_d;
            load_q      <= load_d;
            start_q     <= start_d;
            tick_q      <= tick_d;
            fault_q     <= fault_d;
            pend_q      <= pend_d;
            sh_load_q   <= sh_load_d;
            sh_dwell_q  <= sh_dwell_d;
            act_load_q  <= act_load_d;
            act_dwell_q <= act_dwell_d;
        end
    end

    assign desired_load = load_q;
    assign start        = start_q;
    assign seg_idx      = seg_q;
    assign period_tick  = tick_q;
    assign fault        = fault_q;
endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of segment dwell counters in clk cycles.
REQ-002 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  enable periodic sequencing.
REQ-005 SHALL have ports cfg_we/cfg_addr[1:0]/cfg_load[5:0]/cfg_dwell[CNT_W-1:0]  input  write one shadow-table segment entry.
REQ-006 SHALL have port cfg_commit  input  1  one-cycle request to copy the shadow table to the active table.
REQ-007 SHALL have port short_in  input  1  short indication from the downstream commutation block.
REQ-008 SHALL have port fault_clr  input  1  clears latched fault.
REQ-009 SHALL have port desired_load  output  6  three 2-bit phase selects (00 NUL, 01 A, 10 B, 11 C) fed to the commutation DesiredLoad input.
REQ-010 SHALL have port start  output  1  one-cycle pulse requesting commutation to desired_load.
REQ-011 SHALL have ports seg_idx[1:0], period_tick, fault  output  active segment, one-cycle period-wrap pulse, latched fault.

Function
REQ-012 SHALL hold 4-entry shadow and active tables of {load[5:0], dwell[CNT_W-1:0]}; cfg_we writes shadow[cfg_addr] at the clock edge.
REQ-013 SHALL implement states IDLE, RUN, DRAIN, FAULT.
REQ-014 IDLE: cfg_commit copies shadow to active on the next edge; pending flag stays clear.
REQ-015 IDLE->RUN when en=1 and at least one active dwell is non-zero; otherwise remain IDLE with desired_load=NUL.
REQ-016 On entry to a segment i with dwell[i]!=0: desired_load=load[i], seg_idx=i, and start=1 in the same cycle; the segment lasts exactly dwell[i] cycles including that cycle.
REQ-017 Segments with dwell 0 SHALL be skipped in zero cycles (next non-zero segment entered directly, searching in index order with wrap).
REQ-018 Wrap from the last non-zero segment back to the first SHALL assert period_tick for one cycle, coincident with the first segment's entry cycle.
REQ-019 In RUN, cfg_commit SHALL set a pending flag; the shadow-to-active copy occurs at the next period wrap, and the wrapping segment uses the new table.
REQ-020 cfg_commit coincident with a wrap SHALL take effect at that wrap.
REQ-021 en=0 in RUN SHALL move to DRAIN; DRAIN completes the current period, then drives desired_load=NUL with one start pulse and enters IDLE.
REQ-022 en returning to 1 during DRAIN SHALL return to RUN without interruption.
REQ-023 short_in=1 in any state SHALL, on the next edge, enter FAULT: fault=1, desired_load=NUL, no start pulse, counters cleared.
REQ-024 FAULT->IDLE only when fault_clr=1 and short_in=0 in the same cycle; fault clears on that edge.
REQ-025 Dwell counter SHALL be CNT_W bits, count down, never wrap; maximum segment length 2^CNT_W-1 cycles.

Reset
REQ-026 While rst=0: state=IDLE, both tables zero (load NUL, dwell 0), desired_load=6'b000000, start=0, seg_idx=0, period_tick=0, fault=0, pending=0.
REQ-027 Reset asserted mid-segment SHALL abort immediately without a start pulse; first start after release follows REQ-015.

Configuration
REQ-028 Macro SEQ_SKIP_SAME_EN: when defined, a segment whose load equals the currently driven desired_load SHALL generate no start pulse (timing otherwise unchanged); when undefined, every entered segment pulses start.

Verification
REQ-029 Table {A,B,C}x3 (6'b011011),d=4 / (6'b101110),d=2 / dwell2,3=0, en=1 -> start at cycles 0,4,6,10; period_tick at 6; seg_idx 0,1,0.
REQ-030 All dwells 0, en=1 -> stays IDLE, desired_load=0, no start for 100 cycles.
REQ-031 cfg_commit mid-period with new seg0 load 6'b110110 -> old table until wrap; new load and start exactly at period_tick.
REQ-032 short_in pulse during segment 1 -> next cycle fault=1, desired_load=0, no start; fault_clr with short_in=1 ignored; fault_clr with short_in=0 -> IDLE.
REQ-033 Two consecutive segments with identical load 6'b011011: with SEQ_SKIP_SAME_EN one start per period; without it two.
REQ-034 en dropped in segment 0 -> period completes, NUL with one start, IDLE; rst=0 mid-segment -> all outputs zero asynchronously.
